ip_filter_cam_arb: RTL and testbench
====================================

// Module: ip_filter_cam_arb
// PURPOSE
//  Shares the single-lookup IP-protocol filter CAM between NUM_REQ parser lanes. Each cycle,
//  round-robin picks one lane's protocol tag, drives the CAM read port, and stores
//  dst-id/hit in that lane's response slot. A config handshake stops lookups so
//  software/control logic can rewrite CAM tags/data safely.
// PARAMETERS
//  NUM_REQ     4   number of lookup requesters (>=2)
//  PROTOCOL_W  8   IP protocol tag width
//  DST_ID_W    1   CAM result (destination id) width
//  CNT_W       32  statistics counter width
// PORTS
//  clk            in   1                    clock; all state on posedge
//  rst_n          in   1                    reset, asynchronous, active-low
//  req_val        in   NUM_REQ              per-lane lookup request valid
//  req_tag        in   NUM_REQ*PROTOCOL_W   per-lane protocol tag (lane i = bits [i*PW +: PW])
//  req_rdy        out  NUM_REQ              per-lane accept; one-hot or zero
//  resp_val       out  NUM_REQ              per-lane result valid
//  resp_data      out  NUM_REQ*DST_ID_W     per-lane dst id
//  resp_hit       out  NUM_REQ              per-lane CAM hit
//  resp_rdy       in   NUM_REQ              per-lane result consume
//  cam_rd_val     out  1                    CAM lookup strobe
//  cam_rd_tag     out  PROTOCOL_W           CAM lookup tag
//  cam_rd_data    in   DST_ID_W             CAM result, combinational same cycle
//  cam_rd_hit     in   1                    CAM hit, combinational same cycle
//  cfg_req        in   1                    request exclusive CAM access for reconfiguration
//  cfg_gnt        out  1                    exclusive access granted (registered)
//  stat_lookups   out  CNT_W                lookups issued, saturating
//  stat_misses    out  CNT_W                lookups with cam_rd_hit=0, saturating
// BEHAVIOUR
//  Reset (async, rst_n=0): FSM=ARB, rr_ptr=0, all resp slots empty (resp_val=0, resp_data=0,
//   resp_hit=0), cfg_gnt=0, stat_*=0. req_rdy=0, cam_rd_val=0 while in reset. Mid-op reset
//   drops in-flight results; no partial state survives.
//  Lane i eligible: req_val[i] & (slot i empty | (resp_val[i] & resp_rdy[i]) this cycle).
//  FSM ARB: if cfg_req=1 -> no grant this cycle, next state CFG. Else if any lane eligible ->
//   grant first eligible lane scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ; req_rdy[g]=1,
//   cam_rd_val=1, cam_rd_tag=req_tag[g]; slot g <= {cam_rd_data, cam_rd_hit}, resp_val[g]<=1;
//   rr_ptr <= (g+1) mod NUM_REQ. No eligible lane: rr_ptr unchanged, cam_rd_val=0.
//  FSM CFG: cfg_gnt=1 (registered, first high the cycle after cfg_req seen in ARB); no grants,
//   cam_rd_val=0. When cfg_req=0: next state ARB, cfg_gnt low next cycle, lookups resume that cycle.
//  cfg has strict priority; lookups may starve while cfg_req held (by design).
//  Responses: slot i cleared on resp_val[i]&resp_rdy[i] unless refilled same cycle (refill wins,
//   resp_val stays 1). resp_data/resp_hit stable while resp_val=1 & resp_rdy=0.
//  Latency: accept in cycle N -> resp_val in N+1. Throughput 1 lookup/cycle aggregate,
//   1 lookup per lane per cycle with resp_rdy held high.
//  Miss: resp_hit=0, resp_data = cam_rd_data as returned (0 from CAM on miss).
//  Pending responses in slots are unaffected by entering/leaving CFG.
//  Stats: stat_lookups += 1 per cam_rd_val; stat_misses += 1 per cam_rd_val & !cam_rd_hit;
//   both saturate at all-ones (no wrap).
// TESTING
//  1 Reset: rst_n low mid-stream -> all outputs 0 immediately, rr_ptr=0 after release.
//  2 Lanes 0..3 all req_val=1, resp_rdy=1 -> grants 0,1,2,3,0 on consecutive cycles; resp one cycle later.
//  3 Lane 2 tag 0x11 (UDP, hit, data 0) then tag 0x06 (miss) -> resp_hit 1 then 0; stat_lookups=2, stat_misses=1.
//  4 Lane 1 resp_rdy=0 with slot full, req_val=1 -> req_rdy[1]=0, data held; resp_rdy=1 -> pop and refill same cycle.
//  5 cfg_req raised during full traffic -> no cam_rd_val from that cycle, cfg_gnt=1 next; drop -> grants resume.
//  6 Force stat_lookups to all-ones-1, two more lookups -> counter holds all-ones.

Source files
------------

// File: rtl/ip_filter_cam_arb.sv
`default_nettype none
// ============================================================================
// Module   : ip_filter_cam_arb
// Purpose  : Round-robin sharing of a single-lookup IP-protocol filter CAM
//            between NUM_REQ parser lanes, with per-lane response slots,
//            a configuration lockout handshake and saturating statistics.
// Revision : 1.0 - initial release
// ============================================================================
module ip_filter_cam_arb #(
  parameter int NUM_REQ    = 4,
  parameter int PROTOCOL_W = 8,
  parameter int DST_ID_W   = 1,
  parameter int CNT_W      = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_val,
  input  logic [NUM_REQ*PROTOCOL_W-1:0]  req_tag,
  output logic [NUM_REQ-1:0]             req_rdy,
  output logic [NUM_REQ-1:0]             resp_val,
  output logic [NUM_REQ*DST_ID_W-1:0]    resp_data,
  output logic [NUM_REQ-1:0]             resp_hit,
  input  logic [NUM_REQ-1:0]             resp_rdy,
  output logic                           cam_rd_val,
  output logic [PROTOCOL_W-1:0]          cam_rd_tag,
  input  logic [DST_ID_W-1:0]            cam_rd_data,
  input  logic                           cam_rd_hit,
  input  logic                           cfg_req,
  output logic                           cfg_gnt,
  output logic [CNT_W-1:0]               stat_lookups,
  output logic [CNT_W-1:0]               stat_misses
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [0:0] {
    ST_ARB = 1'b0,
    ST_CFG = 1'b1
  } state_t;

  state_t                       r_state;
  logic                         r_cfg_gnt;
  logic [PTR_W-1:0]             r_rr_ptr;
  logic [NUM_REQ-1:0]           r_resp_val;
  logic [NUM_REQ-1:0]           r_resp_hit;
  logic [NUM_REQ*DST_ID_W-1:0]  r_resp_data;
  logic [CNT_W-1:0]             r_lookups;
  logic [CNT_W-1:0]             r_misses;

  logic                         w_arb_en;
  logic [NUM_REQ-1:0]           w_elig;
  logic [NUM_REQ-1:0]           w_gnt_oh;
  logic                         w_gnt_any;
  logic [PTR_W-1:0]             w_gnt_idx;
  logic [PTR_W-1:0]             w_rr_next;
  logic [PROTOCOL_W-1:0]        w_tag;

  // Grants only while out of reset, in ARB, and with no pending cfg request.
  assign w_arb_en = rst_n && (r_state == ST_ARB) && !cfg_req;

  // A lane may be served if its slot is empty or is being drained this cycle.
  assign w_elig = req_val & (~r_resp_val | resp_rdy);

  // Round-robin scan starting at r_rr_ptr; first eligible lane wins.
  always_comb begin
    w_gnt_oh  = '0;
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      logic [PTR_W:0] idx;
      idx = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
      if (idx >= (PTR_W+1)'(NUM_REQ)) begin
        idx = idx - (PTR_W+1)'(NUM_REQ);
      end
      if (w_arb_en && !w_gnt_any && w_elig[idx[PTR_W-1:0]]) begin
        w_gnt_any                 = 1'b1;
        w_gnt_idx                 = idx[PTR_W-1:0];
        w_gnt_oh[idx[PTR_W-1:0]]  = 1'b1;
      end
    end
  end

  // Pointer advance wraps explicitly so NUM_REQ need not be a power of two.
  assign w_rr_next = (w_gnt_idx == PTR_W'(NUM_REQ-1)) ? '0 : (w_gnt_idx + 1'b1);

  // Tag mux driven by the one-hot grant; idle CAM bus reads zero.
  always_comb begin
    w_tag = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt_oh[i]) begin
        w_tag = req_tag[i*PROTOCOL_W +: PROTOCOL_W];
      end
    end
  end

  assign req_rdy    = w_gnt_oh;
  assign cam_rd_val = w_gnt_any;
  assign cam_rd_tag = w_tag;

  // Arbiter/config FSM with registered grant output and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_ARB;
      r_cfg_gnt <= 1'b0;
      r_rr_ptr  <= '0;
    end else begin
      case (r_state)
        ST_ARB: begin
          if (cfg_req) begin
            r_state   <= ST_CFG;
            r_cfg_gnt <= 1'b1;
          end else if (w_gnt_any) begin
            r_rr_ptr  <= w_rr_next;
          end
        end
        ST_CFG: begin
          if (!cfg_req) begin
            r_state   <= ST_ARB;
            r_cfg_gnt <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_ARB;
          r_cfg_gnt <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_gnt = r_cfg_gnt;

  generate
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
      // Per-lane response slot: refill beats drain, drain clears the slot.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_resp_val[g]                          <= 1'b0;
          r_resp_hit[g]                          <= 1'b0;
          r_resp_data[g*DST_ID_W +: DST_ID_W]    <= '0;
        end else if (w_gnt_oh[g]) begin
          r_resp_val[g]                          <= 1'b1;
          r_resp_hit[g]                          <= cam_rd_hit;
          r_resp_data[g*DST_ID_W +: DST_ID_W]    <= cam_rd_data;
        end else if (r_resp_val[g] && resp_rdy[g]) begin
          r_resp_val[g]                          <= 1'b0;
          r_resp_hit[g]                          <= 1'b0;
          r_resp_data[g*DST_ID_W +: DST_ID_W]    <= '0;
        end
      end
    end
  endgenerate

  assign resp_val  = r_resp_val;
  assign resp_hit  = r_resp_hit;
  assign resp_data = r_resp_data;

  // Saturating lookup and miss counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lookups <= '0;
      r_misses  <= '0;
    end else if (w_gnt_any) begin
      if (r_lookups != {CNT_W{1'b1}}) begin
        r_lookups <= r_lookups + 1'b1;
      end
      if (!cam_rd_hit && (r_misses != {CNT_W{1'b1}})) begin
        r_misses <= r_misses + 1'b1;
      end
    end
  end

  assign stat_lookups = r_lookups;
  assign stat_misses  = r_misses;

endmodule
`default_nettype wire

// File: tb/tb_ip_filter_cam_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_ip_filter_cam_arb
// Purpose  : Directed self-checking bench for ip_filter_cam_arb with a small
//            behavioural CAM (0x01->hit/1, 0x11->hit/0, 0x32->hit/1, else miss).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ip_filter_cam_arb;

  localparam int NR  = 4;
  localparam int PW  = 8;
  localparam int DW  = 1;
  localparam int CW  = 4;

  logic              clk;
  logic              rst_n;
  logic [NR-1:0]     req_val;
  logic [NR*PW-1:0]  req_tag;
  logic [NR-1:0]     req_rdy;
  logic [NR-1:0]     resp_val;
  logic [NR*DW-1:0]  resp_data;
  logic [NR-1:0]     resp_hit;
  logic [NR-1:0]     resp_rdy;
  logic              cam_rd_val;
  logic [PW-1:0]     cam_rd_tag;
  logic [DW-1:0]     cam_rd_data;
  logic              cam_rd_hit;
  logic              cfg_req;
  logic              cfg_gnt;
  logic [CW-1:0]     stat_lookups;
  logic [CW-1:0]     stat_misses;

  int total;
  int bad;

  // Default lane tags and the CAM results they produce.
  logic [PW-1:0] tags  [NR];
  logic          hits  [NR];
  logic          datas [NR];

  ip_filter_cam_arb #(
    .NUM_REQ(NR), .PROTOCOL_W(PW), .DST_ID_W(DW), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_val(req_val), .req_tag(req_tag), .req_rdy(req_rdy),
    .resp_val(resp_val), .resp_data(resp_data), .resp_hit(resp_hit), .resp_rdy(resp_rdy),
    .cam_rd_val(cam_rd_val), .cam_rd_tag(cam_rd_tag),
    .cam_rd_data(cam_rd_data), .cam_rd_hit(cam_rd_hit),
    .cfg_req(cfg_req), .cfg_gnt(cfg_gnt),
    .stat_lookups(stat_lookups), .stat_misses(stat_misses)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural CAM, combinational same cycle.
  always_comb begin
    cam_rd_hit  = 1'b0;
    cam_rd_data = '0;
    case (cam_rd_tag)
      8'h01: begin cam_rd_hit = 1'b1; cam_rd_data = 1'b1; end
      8'h11: begin cam_rd_hit = 1'b1; cam_rd_data = 1'b0; end
      8'h32: begin cam_rd_hit = 1'b1; cam_rd_data = 1'b1; end
      default: begin cam_rd_hit = 1'b0; cam_rd_data = 1'b0; end
    endcase
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_default_tags;
    req_tag = {tags[3], tags[2], tags[1], tags[0]};
  endtask

  task automatic do_reset;
    rst_n    = 1'b0;
    req_val  = '0;
    resp_rdy = '0;
    cfg_req  = 1'b0;
    load_default_tags();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_val = '1; resp_rdy = '1; cfg_req = 1'b0;
    load_default_tags();
    repeat (2) @(posedge clk);
    #1;
    total++; if (req_rdy !== 4'b0000) begin bad++; $display("FAIL rst_hold_req_rdy got=%b exp=%b", req_rdy, 4'b0000); end
    total++; if (cam_rd_val !== 1'b0) begin bad++; $display("FAIL rst_hold_cam_rd_val got=%b exp=0", cam_rd_val); end
    total++; if (cfg_gnt !== 1'b0) begin bad++; $display("FAIL rst_hold_cfg_gnt got=%b exp=0", cfg_gnt); end
    rst_n = 1'b1;
    tick(); tick(); tick();
    // mid-stream asynchronous reset
    #3 rst_n = 1'b0;
    #1;
    total++; if (resp_val !== 4'b0000) begin bad++; $display("FAIL mid_rst_resp_val got=%b exp=%b", resp_val, 4'b0000); end
    total++; if (req_rdy !== 4'b0000) begin bad++; $display("FAIL mid_rst_req_rdy got=%b exp=%b", req_rdy, 4'b0000); end
    total++; if (cam_rd_val !== 1'b0) begin bad++; $display("FAIL mid_rst_cam_rd_val got=%b exp=0", cam_rd_val); end
    total++; if (stat_lookups !== 4'd0) begin bad++; $display("FAIL mid_rst_lookups got=%0d exp=0", stat_lookups); end
    total++; if ({resp_hit, resp_data} !== 8'h00) begin bad++; $display("FAIL mid_rst_slots got=%h exp=00", {resp_hit, resp_data}); end
    #1 rst_n = 1'b1;
    #1;
    total++; if (req_rdy !== 4'b0001) begin bad++; $display("FAIL post_rst_ptr got=%b exp=%b", req_rdy, 4'b0001); end
    tick();
    total++; if (resp_val !== 4'b0001) begin bad++; $display("FAIL post_rst_resp got=%b exp=%b", resp_val, 4'b0001); end
    req_val = '0;
  endtask

  task automatic test_round_robin;
    do_reset();
    req_val = '1; resp_rdy = '1;
    for (int c = 0; c < 5; c++) begin
      int e;
      e = c % NR;
      #1;
      total++; if (req_rdy !== (4'b0001 << e)) begin bad++; $display("FAIL rr_grant%0d got=%b exp=%b", c, req_rdy, 4'b0001 << e); end
      total++; if (cam_rd_tag !== tags[e]) begin bad++; $display("FAIL rr_tag%0d got=%h exp=%h", c, cam_rd_tag, tags[e]); end
      tick();
      total++; if (resp_val !== (4'b0001 << e)) begin bad++; $display("FAIL rr_resp%0d got=%b exp=%b", c, resp_val, 4'b0001 << e); end
      total++; if ({resp_hit[e], resp_data[e]} !== {hits[e], datas[e]}) begin bad++; $display("FAIL rr_result%0d got=%b exp=%b", c, {resp_hit[e], resp_data[e]}, {hits[e], datas[e]}); end
    end
    req_val = '0;
    total++; if (stat_lookups !== 4'd5) begin bad++; $display("FAIL rr_lookups got=%0d exp=5", stat_lookups); end
    total++; if (stat_misses !== 4'd1) begin bad++; $display("FAIL rr_misses got=%0d exp=1", stat_misses); end
  endtask

  task automatic test_hit_miss;
    do_reset();
    resp_rdy = '1; req_val = 4'b0100; req_tag[23:16] = 8'h11;
    #1;
    total++; if (req_rdy !== 4'b0100 || cam_rd_tag !== 8'h11) begin bad++; $display("FAIL hm_grant1 got=%b/%h exp=0100/11", req_rdy, cam_rd_tag); end
    tick();
    total++; if ({resp_val[2], resp_hit[2], resp_data[2]} !== 3'b110) begin bad++; $display("FAIL hm_hit got=%b exp=110", {resp_val[2], resp_hit[2], resp_data[2]}); end
    req_tag[23:16] = 8'h06;
    #1;
    total++; if (req_rdy !== 4'b0100) begin bad++; $display("FAIL hm_grant2 got=%b exp=0100", req_rdy); end
    tick();
    total++; if ({resp_val[2], resp_hit[2], resp_data[2]} !== 3'b100) begin bad++; $display("FAIL hm_miss got=%b exp=100", {resp_val[2], resp_hit[2], resp_data[2]}); end
    req_val = '0;
    tick();
    total++; if (resp_val !== 4'b0000) begin bad++; $display("FAIL hm_drain got=%b exp=0000", resp_val); end
    total++; if (stat_lookups !== 4'd2 || stat_misses !== 4'd1) begin bad++; $display("FAIL hm_stats got=%0d/%0d exp=2/1", stat_lookups, stat_misses); end
  endtask

  task automatic test_backpressure;
    do_reset();
    resp_rdy = '0; req_val = 4'b0010; req_tag[15:8] = 8'h01;
    #1;
    total++; if (req_rdy !== 4'b0010) begin bad++; $display("FAIL bp_first got=%b exp=0010", req_rdy); end
    tick();
    req_tag[15:8] = 8'h06;
    #1;
    total++; if (req_rdy !== 4'b0000 || cam_rd_val !== 1'b0) begin bad++; $display("FAIL bp_block got=%b/%b exp=0000/0", req_rdy, cam_rd_val); end
    tick();
    total++; if ({resp_val[1], resp_hit[1], resp_data[1]} !== 3'b111) begin bad++; $display("FAIL bp_held got=%b exp=111", {resp_val[1], resp_hit[1], resp_data[1]}); end
    resp_rdy = 4'b0010;
    #1;
    total++; if (req_rdy !== 4'b0010) begin bad++; $display("FAIL bp_refill_grant got=%b exp=0010", req_rdy); end
    tick();
    total++; if ({resp_val[1], resp_hit[1], resp_data[1]} !== 3'b100) begin bad++; $display("FAIL bp_refill got=%b exp=100", {resp_val[1], resp_hit[1], resp_data[1]}); end
    req_val = '0;
    tick();
    total++; if (resp_val !== 4'b0000) begin bad++; $display("FAIL bp_pop got=%b exp=0000", resp_val); end
  endtask

  task automatic test_cfg;
    do_reset();
    req_val = '1; resp_rdy = '1;
    tick(); tick();
    cfg_req = 1'b1; resp_rdy = '0;
    #1;
    total++; if (cam_rd_val !== 1'b0 || req_rdy !== 4'b0000) begin bad++; $display("FAIL cfg_block got=%b/%b exp=0/0000", cam_rd_val, req_rdy); end
    total++; if (cfg_gnt !== 1'b0) begin bad++; $display("FAIL cfg_gnt_early got=%b exp=0", cfg_gnt); end
    tick();
    total++; if (cfg_gnt !== 1'b1 || cam_rd_val !== 1'b0) begin bad++; $display("FAIL cfg_granted got=%b/%b exp=1/0", cfg_gnt, cam_rd_val); end
    total++; if (resp_val !== 4'b0010 || resp_hit[1] !== 1'b1) begin bad++; $display("FAIL cfg_pending got=%b/%b exp=0010/1", resp_val, resp_hit[1]); end
    tick();
    total++; if (cfg_gnt !== 1'b1 || resp_val !== 4'b0010) begin bad++; $display("FAIL cfg_hold got=%b/%b exp=1/0010", cfg_gnt, resp_val); end
    cfg_req = 1'b0;
    #1;
    total++; if (cam_rd_val !== 1'b0) begin bad++; $display("FAIL cfg_exit_cycle got=%b exp=0", cam_rd_val); end
    tick();
    total++; if (cfg_gnt !== 1'b0) begin bad++; $display("FAIL cfg_release got=%b exp=0", cfg_gnt); end
    total++; if (cam_rd_val !== 1'b1 || req_rdy !== 4'b0100) begin bad++; $display("FAIL cfg_resume got=%b/%b exp=1/0100", cam_rd_val, req_rdy); end
    tick();
    total++; if (resp_val !== 4'b0110) begin bad++; $display("FAIL cfg_resume_resp got=%b exp=0110", resp_val); end
    req_val = '0;
  endtask

  task automatic test_back_to_back_saturate;
    do_reset();
    resp_rdy = '1; req_val = 4'b0001; req_tag[7:0] = 8'h06;
    for (int i = 0; i < 14; i++) begin
      #1;
      total++; if (req_rdy !== 4'b0001) begin bad++; $display("FAIL b2b_grant%0d got=%b exp=0001", i, req_rdy); end
      tick();
    end
    total++; if (stat_lookups !== 4'd14 || stat_misses !== 4'd14) begin bad++; $display("FAIL sat_pre got=%0d/%0d exp=14/14", stat_lookups, stat_misses); end
    tick(); tick();
    total++; if (stat_lookups !== 4'd15 || stat_misses !== 4'd15) begin bad++; $display("FAIL sat_hold got=%0d/%0d exp=15/15", stat_lookups, stat_misses); end
    tick();
    total++; if (stat_lookups !== 4'd15 || stat_misses !== 4'd15) begin bad++; $display("FAIL sat_nowrap got=%0d/%0d exp=15/15", stat_lookups, stat_misses); end
    req_val = '0;
    tick();
  endtask

  initial begin
    total = 0; bad = 0;
    tags  = '{8'h01, 8'h11, 8'h32, 8'h06};
    hits  = '{1'b1, 1'b1, 1'b1, 1'b0};
    datas = '{1'b1, 1'b0, 1'b1, 1'b0};
    rst_n = 1'b0; req_val = '0; resp_rdy = '0; cfg_req = 1'b0; req_tag = '0;
    test_reset();
    test_round_robin();
    test_hit_miss();
    test_backpressure();
    test_cfg();
    test_back_to_back_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
`default_nettype wire
